// File: rtl/pic_pc_stack_if.sv
// Decoder <-> PC/stack unit bundle: PC-action strobes and jump literals in, PC and stack status out.
interface pic_pc_stack_if #(
    parameter int PC_WIDTH    = 13,
    parameter int JADDR_WIDTH = 11,
    parameter int SP_WIDTH    = 3
);
    logic                   pc_incr_en;
    logic                   pc_j_en;
    logic                   pc_j_and_push_en;
    logic                   pc_j_by_pop_en;
    logic [JADDR_WIDTH-1:0] pc_j_addr;
    logic                   int_vector_en;
    logic                   pclath_wr_en;
    logic [PC_WIDTH-9:0]    pclath_in;
    logic                   pcl_wr_en;
    logic [7:0]             pcl_in;
    logic                   stk_flag_clr;

    logic [PC_WIDTH-1:0]    pc_out;
    logic [PC_WIDTH-9:0]    pclath_out;
    logic [SP_WIDTH-1:0]    stack_ptr;
    logic                   stack_full;
    logic                   stack_empty;
    logic                   stk_ovf;
    logic                   stk_unf;
    logic                   stack_reset_req;

    modport master (
        output pc_incr_en, pc_j_en, pc_j_and_push_en, pc_j_by_pop_en, pc_j_addr,
               int_vector_en, pclath_wr_en, pclath_in, pcl_wr_en, pcl_in, stk_flag_clr,
        input  pc_out, pclath_out, stack_ptr, stack_full, stack_empty, stk_ovf, stk_unf,
               stack_reset_req
    );

    modport slave (
        input  pc_incr_en, pc_j_en, pc_j_and_push_en, pc_j_by_pop_en, pc_j_addr,
               int_vector_en, pclath_wr_en, pclath_in, pcl_wr_en, pcl_in, stk_flag_clr,
        output pc_out, pclath_out, stack_ptr, stack_full, stack_empty, stk_ovf, stk_unf,
               stack_reset_req
    );
endinterface

// File: rtl/pic_pc_stack_unit.sv
// Program counter, PCLATH paging latch and circular hardware return stack.
// PIC_STACK_OVF_RESET_EN: overflow/underflow discard the stack op and pulse stack_reset_req.
module pic_pc_stack_unit #(
    parameter int                    PC_WIDTH     = 13,
    parameter int                    JADDR_WIDTH  = 11,
    parameter int                    STACK_DEPTH  = 8,
    parameter int                    SP_WIDTH     = 3,
    parameter logic [PC_WIDTH-1:0]   RESET_VECTOR = 13'h000,
    parameter logic [PC_WIDTH-1:0]   INT_VECTOR   = 13'h004
) (
    input  logic             clk,
    input  logic             rst,
    pic_pc_stack_if.slave    bus
);
    localparam int                PLW     = PC_WIDTH - 8;
    localparam logic [SP_WIDTH:0] DEPTH_C = (SP_WIDTH+1)'(STACK_DEPTH);

    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PLW-1:0]      pclath_q, pclath_d;
    logic [SP_WIDTH-1:0] ptr_q, ptr_d;
    logic [SP_WIDTH:0]   cnt_q, cnt_d;
    logic                ovf_q, ovf_d;
    logic                unf_q, unf_d;
    logic [PC_WIDTH-1:0] stack_q [STACK_DEPTH];

    logic [PC_WIDTH-1:0] pc_plus1, target, push_data;
    logic [SP_WIDTH-1:0] ptr_m1;
    logic                full, empty, push, stk_wr_en, ovf_set, unf_set;
`ifdef PIC_STACK_OVF_RESET_EN
    logic                req_q, req_d;
`endif

    assign pc_plus1 = pc_q + PC_WIDTH'(1);
    assign ptr_m1   = ptr_q - SP_WIDTH'(1);
    assign target   = {pclath_q[PLW-1:JADDR_WIDTH-8], bus.pc_j_addr};
    assign full     = (cnt_q == DEPTH_C);
    assign empty    = (cnt_q == '0);

    always_comb begin
        pc_d      = pc_q;
        pclath_d  = bus.pclath_wr_en ? bus.pclath_in : pclath_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        push      = 1'b0;
        push_data = pc_q;
        stk_wr_en = 1'b0;
        ovf_set   = 1'b0;
        unf_set   = 1'b0;
`ifdef PIC_STACK_OVF_RESET_EN
        req_d     = 1'b0;
`endif
        if (bus.int_vector_en) begin
            push      = 1'b1;
            push_data = pc_q;
            pc_d      = INT_VECTOR;
        end else if (bus.pc_j_by_pop_en) begin
            if (empty) begin
                unf_set = 1'b1;
`ifdef PIC_STACK_OVF_RESET_EN
                pc_d    = RESET_VECTOR;
                req_d   = 1'b1;
`else
                pc_d    = stack_q[ptr_m1];
                ptr_d   = ptr_m1;
`endif
            end else begin
                pc_d  = stack_q[ptr_m1];
                ptr_d = ptr_m1;
                cnt_d = cnt_q - 1'b1;
            end
        end else if (bus.pc_j_and_push_en) begin
            push      = 1'b1;
            push_data = pc_plus1;
            pc_d      = target;
        end else if (bus.pc_j_en) begin
            pc_d = target;
        end else if (bus.pcl_wr_en) begin
            pc_d = {pclath_q, bus.pcl_in};
        end else if (bus.pc_incr_en) begin
            pc_d = pc_plus1;
        end

        // A full push still loads the new PC; only the stack side changes behaviour.
        if (push) begin
            if (full) begin
                ovf_set = 1'b1;
`ifdef PIC_STACK_OVF_RESET_EN
                req_d     = 1'b1;
`else
                stk_wr_en = 1'b1;
                ptr_d     = ptr_q + SP_WIDTH'(1);
`endif
            end else begin
                stk_wr_en = 1'b1;
                ptr_d     = ptr_q + SP_WIDTH'(1);
                cnt_d     = cnt_q + 1'b1;
            end
        end

        ovf_d = ovf_set | (ovf_q & ~bus.stk_flag_clr);
        unf_d = unf_set | (unf_q & ~bus.stk_flag_clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= RESET_VECTOR;
            pclath_q <= '0;
            ptr_q    <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            pclath_q <= pclath_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (stk_wr_en && !rst) stack_q[ptr_q] <= push_data;
    end

`ifdef PIC_STACK_OVF_RESET_EN
    always_ff @(posedge clk) begin
        if (rst) req_q <= 1'b0;
        else     req_q <= req_d;
    end
    assign bus.stack_reset_req = req_q;
`else
    assign bus.stack_reset_req = 1'b0;
`endif

    assign bus.pc_out      = pc_q;
    assign bus.pclath_out  = pclath_q;
    assign bus.stack_ptr   = ptr_q;
    assign bus.stack_full  = full;
    assign bus.stack_empty = empty;
    assign bus.stk_ovf     = ovf_q;
    assign bus.stk_unf     = unf_q;
endmodule
